// File: rtl/layer1_conv_engine.sv
// Layer-1 convolution core: one 5x5 window in, one requantised int8 activation
// per output channel out, one channel at a time, from a config-loaded register file.
module layer1_conv_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_CH     = 6,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 8,
    parameter int CFG_AW     = 8,
    localparam int CH_W      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     win_valid,
    output logic                     in_ready,
    input  logic [25*DATA_WIDTH-1:0] win_flat,
    input  logic                     cfg_we,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [ACC_WIDTH-1:0]     cfg_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last
);

    localparam int NTAP  = 25;
    localparam int NW    = OUT_CH * NTAP;
    localparam int NADDR = OUT_CH * (NTAP + 1);

    localparam logic [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [25*DATA_WIDTH-1:0]      win_q;
    logic                          out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
    logic [CH_W-1:0]               out_ch_q, out_ch_d;
    logic                          out_last_q, out_last_d;

    logic signed [DATA_WIDTH-1:0]  w_q [NW];
    logic signed [ACC_WIDTH-1:0]   b_q [OUT_CH];

    logic signed [DATA_WIDTH-1:0]  w_sel [NTAP];
    logic signed [ACC_WIDTH-1:0]   b_sel;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]          relu;
    logic [ACC_WIDTH-1:0]          shifted;
    logic [DATA_WIDTH-1:0]         q_sat;

    logic cfg_ok;
    logic is_last;

    assign in_ready  = (state_q == S_IDLE);
    assign cfg_ok    = cfg_we && (state_q == S_IDLE) && (int'(cfg_addr) < NADDR);
    assign is_last   = (int'(ch_q) == OUT_CH - 1);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

    // NOTE: every variable gets a default before the conditional loop, so no latch is inferred.
    always_comb begin
        b_sel = '0;
        for (int t = 0; t < NTAP; t++) begin
            w_sel[t] = '0;
        end
        for (int k = 0; k < OUT_CH; k++) begin
            if (int'(ch_q) == k) begin
                b_sel = b_q[k];
                for (int t = 0; t < NTAP; t++) begin
                    w_sel[t] = w_q[k*NTAP + t];
                end
            end
        end
    end

    // NOTE: blocking assignments here on purpose: each step of the sum must see the previous one.
    always_comb begin
        prod = '0;
        acc  = b_sel;
        for (int t = 0; t < NTAP; t++) begin
            prod = $signed(win_q[t*DATA_WIDTH +: DATA_WIDTH]) * w_sel[t];
            acc  = acc + ACC_WIDTH'(prod);
        end
    end

    // ReLU, floor shift, clamp to the positive int8 range
    always_comb begin
        relu    = acc[ACC_WIDTH-1] ? '0 : acc;
        shifted = relu >> SHIFT;
        q_sat   = (shifted > QMAX) ? QMAX[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d = S_MAC;
                    ch_d    = '0;
                end
            end
            S_MAC: begin
                out_data_d  = q_sat;
                out_ch_d    = ch_q;
                out_last_d  = is_last;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (is_last) begin
                        state_d = S_IDLE;
                        ch_d    = '0;
                    end else begin
                        state_d = S_MAC;
                        ch_d    = ch_q + CH_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            if (win_valid && in_ready) begin
                win_q <= win_flat;
            end
        end
    end

    // NOTE: the kernel register file is reset because a reset must leave the engine producing
    // zeros until it is reconfigured; it is therefore flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                w_q[i] <= '0;
            end
            for (int k = 0; k < OUT_CH; k++) begin
                b_q[k] <= '0;
            end
        end else if (cfg_ok) begin
            for (int i = 0; i < NW; i++) begin
                if (int'(cfg_addr) == i) begin
                    w_q[i] <= cfg_wdata[DATA_WIDTH-1:0];
                end
            end
            for (int k = 0; k < OUT_CH; k++) begin
                if (int'(cfg_addr) == NW + k) begin
                    b_q[k] <= cfg_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer1_conv_engine.sv
// Scoreboard bench for layer1_conv_engine: a behavioural model predicts every
// channel result when a window is accepted; a monitor pops and compares on handshake.
module tb_layer1_conv_engine;

    localparam int DW  = 8;
    localparam int NCH = 6;

    typedef struct {
        logic [7:0] data;
        logic [2:0] ch;
        logic       last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         win_valid;
    logic         in_ready;
    logic [199:0] win_flat;
    logic         cfg_we;
    logic [7:0]   cfg_addr;
    logic [31:0]  cfg_wdata;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [2:0]   out_ch;
    logic         out_last;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   n_win   = 0;
    exp_t sb[$];
    int   wm [NCH][25];
    int   bm [NCH];
    logic [7:0] obs_data [NCH];

    always #5 clk = ~clk;

    layer1_conv_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_valid (win_valid),
        .in_ready  (in_ready),
        .win_flat  (win_flat),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] fill(input int v);
        logic [199:0] w;
        for (int t = 0; t < 25; t++) w[t*8 +: 8] = 8'(v);
        return w;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            bm[k] = 0;
            for (int t = 0; t < 25; t++) wm[k][t] = 0;
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int ai;
        logic [7:0] lo;
        ai = int'(a);
        lo = d[7:0];
        if (ai < NCH*25) wm[ai/25][ai%25] = int'($signed(lo));
        else if (ai < NCH*26) bm[ai - NCH*25] = int'(d);
    endtask

    task automatic push_expected(input logic [199:0] w);
        exp_t e;
        int acc;
        logic [7:0] px;
        for (int k = 0; k < NCH; k++) begin
            acc = bm[k];
            for (int t = 0; t < 25; t++) begin
                px  = w[t*8 +: 8];
                acc = acc + int'($signed(px)) * wm[k][t];
            end
            if (acc < 0) acc = 0;
            acc = acc / 256;
            if (acc > 127) acc = 127;
            e.data = 8'(acc);
            e.ch   = 3'(k);
            e.last = (k == NCH-1);
            sb.push_back(e);
        end
    endtask

    // All driver tasks start and end at posedge+1.
    task automatic cfg_write(input int a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = 8'(a);
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(8'(a), d);
    endtask

    task automatic send_window(input logic [199:0] w, input bit do_cfg,
                               input int a, input logic [31:0] d);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < NCH; k++) obs_data[k] = 8'hAA;
        win_valid = 1'b1;
        win_flat  = w;
        if (do_cfg) begin
            cfg_we    = 1'b1;
            cfg_addr  = 8'(a);
            cfg_wdata = d;
            model_write(8'(a), d);
        end
        push_expected(w);
        n_win++;
        @(posedge clk); #1;
        win_valid = 1'b0;
        cfg_we    = 1'b0;
        for (int t = 0; t < 25; t++) win_flat[t*8 +: 8] = 8'($urandom);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_out_ch(input int ch);
        int cyc;
        cyc = 0;
        while (!(out_valid && int'(out_ch) == ch) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_ch", {31'b0, out_valid && int'(out_ch) == ch}, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {24'b0, out_data}, {24'b0, e.data});
                check("out_ch",   {29'b0, out_ch},   {29'b0, e.ch});
                check("out_last", {31'b0, out_last}, {31'b0, e.last});
            end
            if (int'(out_ch) < NCH) obs_data[out_ch] = out_data;
        end
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        win_valid = 1'b0;
        win_flat  = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        out_ready = 1'b1;
        model_clear();
        #23 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_in_ready",  {31'b0, in_ready},  1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data",  {24'b0, out_data},  0);
        check("rst_out_ch",    {29'b0, out_ch},    0);
        check("rst_out_last",  {31'b0, out_last},  0);

        // Unconfigured engine: all zeros, 12 cycles accept-to-idle
        send_window(fill(5), 0, 0, 0);
        wait_idle(cyc);
        check("latency_idle", cyc, 12);
        for (int k = 0; k < NCH; k++) check("zero_cfg", {24'b0, obs_data[k]}, 0);

        // Identity kernel on channel 0
        cfg_write(12, 32'd1);
        cfg_write(150, 32'd0);
        begin
            logic [199:0] w;
            w = fill(0);
            w[12*8 +: 8] = 8'd100;
            send_window(w, 0, 0, 0);
            wait_idle(cyc);
            check("ident_nobias", {24'b0, obs_data[0]}, 0);
            cfg_write(150, 32'd25500);
            send_window(w, 0, 0, 0);
            wait_idle(cyc);
            check("ident_bias", {24'b0, obs_data[0]}, 100);
        end

        // Negative accumulator clipped by ReLU
        for (int t = 0; t < 25; t++) cfg_write(25 + t, 32'hFFFF_FFFF);
        send_window(fill(10), 0, 0, 0);
        wait_idle(cyc);
        check("relu_ch1", {24'b0, obs_data[1]}, 0);

        // Saturation on ch2, a mid-range ch3 for the stall test
        for (int t = 0; t < 25; t++) cfg_write(50 + t, 32'd127);
        cfg_write(75 + 12, 32'd64);
        send_window(fill(127), 0, 0, 0);
        wait_idle(cyc);
        check("sat_ch2", {24'b0, obs_data[2]}, 127);
        check("mid_ch3", {24'b0, obs_data[3]}, 31);

        // Backpressure at ch3 with dropped windows and ignored config writes
        send_window(fill(127), 0, 0, 0);
        wait_out_ch(3);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            win_valid = 1'b1;
            win_flat  = fill(3);
            cfg_we    = 1'b1;
            cfg_addr  = 8'(75 + 12);
            cfg_wdata = 32'd0;
            @(posedge clk); #1;
            check("stall_valid", {31'b0, out_valid}, 1);
            check("stall_ch",    {29'b0, out_ch},    3);
            check("stall_data",  {24'b0, out_data},  31);
            check("stall_inrdy", {31'b0, in_ready},  0);
        end
        win_valid = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        wait_idle(cyc);
        send_window(fill(127), 0, 0, 0);
        wait_idle(cyc);
        check("stall_wt_kept", {24'b0, obs_data[3]}, 31);
        check("out_count", n_out, 6 * n_win);

        // Config write on the same edge as the accept is used by that window
        send_window(fill(0), 1, 150 + 4, 32'd12800);
        wait_idle(cyc);
        check("same_edge_cfg", {24'b0, obs_data[4]}, 50);

        // Reset during OUT of ch2 aborts and clears the kernels
        send_window(fill(20), 0, 0, 0);
        wait_out_ch(2);
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, out_valid}, 0);
        check("abort_inrdy", {31'b0, in_ready},  1);
        sb.delete();
        model_clear();
        n_out = 0;
        n_win = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_window(fill(20), 0, 0, 0);
        wait_idle(cyc);
        for (int k = 0; k < NCH; k++) check("post_rst_zero", {24'b0, obs_data[k]}, 0);
        check("post_rst_count", n_out, 6);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
